// File: rtl/qaoa_kernel_mul_pipe_hs.sv
`default_nettype none
// ============================================================================
// Module   : qaoa_kernel_mul_pipe_hs
// Brief    : Pipelined signed/unsigned multiplier with round, saturate, tag
//            sideband and valid/ready backpressure.
// Revision : 1.0
// ============================================================================
module qaoa_kernel_mul_pipe_hs #(
    parameter int DIN0_WIDTH  = 49,
    parameter int DIN1_WIDTH  = 23,
    parameter int DOUT_WIDTH  = 68,
    parameter int NUM_STAGE   = 3,
    parameter int TAG_WIDTH   = 4,
    parameter int SHIFT_WIDTH = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DIN0_WIDTH-1:0]  din0,
    input  logic [DIN1_WIDTH-1:0]  din1,
    input  logic [1:0]             in_sgn,
    input  logic [SHIFT_WIDTH-1:0] in_shift,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DOUT_WIDTH-1:0]  dout,
    output logic [TAG_WIDTH-1:0]   out_tag,
    output logic                   out_sat,
    output logic                   busy
);

    localparam int A_WIDTH    = DIN0_WIDTH + 1;
    localparam int B_WIDTH    = DIN1_WIDTH + 1;
    localparam int FULL_WIDTH = DIN0_WIDTH + DIN1_WIDTH + 2;
    localparam int CALC_WIDTH = ((FULL_WIDTH > DOUT_WIDTH) ? FULL_WIDTH : DOUT_WIDTH) + 2;
    localparam int SHIFT_MAX  = FULL_WIDTH - 1;
    localparam int LAST_MID   = NUM_STAGE - 1;

    localparam logic signed [CALC_WIDTH-1:0] ONE      = CALC_WIDTH'(1);
    localparam logic signed [CALC_WIDTH-1:0] SAT_SMAX = (ONE <<< (DOUT_WIDTH - 1)) - ONE;
    localparam logic signed [CALC_WIDTH-1:0] SAT_SMIN = -(ONE <<< (DOUT_WIDTH - 1));
    localparam logic signed [CALC_WIDTH-1:0] SAT_UMAX = (ONE <<< DOUT_WIDTH) - ONE;

    logic adv;

    // Whole pipeline moves in lockstep; only a held output blocks it.
    assign adv      = ce & ~(out_valid & ~out_ready);
    assign in_ready = adv;

    logic signed [A_WIDTH-1:0]  a_q;
    logic signed [B_WIDTH-1:0]  b_q;
    logic [LAST_MID:1]          valid_q;
    logic [TAG_WIDTH-1:0]       tag_q   [1:LAST_MID];
    logic [1:0]                 sgn_q   [1:LAST_MID];
    logic [SHIFT_WIDTH-1:0]     shift_q [1:LAST_MID];
    logic [SHIFT_WIDTH-1:0]     shift_clamped;

    always_comb begin
        shift_clamped = in_shift;
        if (int'(in_shift) > SHIFT_MAX) begin
            shift_clamped = SHIFT_WIDTH'(SHIFT_MAX);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= '0;
            for (int k = 1; k < NUM_STAGE; k++) begin
                tag_q[k]   <= '0;
                sgn_q[k]   <= '0;
                shift_q[k] <= '0;
            end
        end else if (adv) begin
            a_q        <= {in_sgn[0] & din0[DIN0_WIDTH-1], din0};
            b_q        <= {in_sgn[1] & din1[DIN1_WIDTH-1], din1};
            valid_q[1] <= in_valid;
            tag_q[1]   <= in_tag;
            sgn_q[1]   <= in_sgn;
            shift_q[1] <= shift_clamped;
            for (int k = 2; k < NUM_STAGE; k++) begin
                valid_q[k] <= valid_q[k-1];
                tag_q[k]   <= tag_q[k-1];
                sgn_q[k]   <= sgn_q[k-1];
                shift_q[k] <= shift_q[k-1];
            end
        end
    end

    logic signed [FULL_WIDTH-1:0] a_full;
    logic signed [FULL_WIDTH-1:0] b_full;
    logic signed [FULL_WIDTH-1:0] product;
    logic signed [FULL_WIDTH-1:0] src_prod;

    assign a_full  = {{(FULL_WIDTH - A_WIDTH){a_q[A_WIDTH-1]}}, a_q};
    assign b_full  = {{(FULL_WIDTH - B_WIDTH){b_q[B_WIDTH-1]}}, b_q};
    assign product = a_full * b_full;

    generate
        if (NUM_STAGE > 2) begin : g_prod_pipe
            logic signed [FULL_WIDTH-1:0] prod_q [2:NUM_STAGE-1];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 2; k < NUM_STAGE; k++) begin
                        prod_q[k] <= '0;
                    end
                end else if (adv) begin
                    prod_q[2] <= product;
                    for (int k = 3; k < NUM_STAGE; k++) begin
                        prod_q[k] <= prod_q[k-1];
                    end
                end
            end

            assign src_prod = prod_q[NUM_STAGE-1];
        end else begin : g_prod_direct
            // Two-stage build: multiply and round/saturate share one cycle.
            assign src_prod = product;
        end
    endgenerate

    logic signed [CALC_WIDTH-1:0] prod_ext;
    logic signed [CALC_WIDTH-1:0] bias;
    logic signed [CALC_WIDTH-1:0] rounded;
    logic signed [CALC_WIDTH-1:0] shifted;
    logic [DOUT_WIDTH-1:0]        dout_next;
    logic                         clip;
    logic [SHIFT_WIDTH-1:0]       src_shift;

    assign src_shift = shift_q[LAST_MID];

    always_comb begin
        prod_ext = {{(CALC_WIDTH - FULL_WIDTH){src_prod[FULL_WIDTH-1]}}, src_prod};
        bias     = '0;
        if (src_shift != '0) begin
            bias = ONE <<< (src_shift - SHIFT_WIDTH'(1));
        end
        rounded   = prod_ext + bias;
        shifted   = rounded >>> src_shift;
        dout_next = shifted[DOUT_WIDTH-1:0];
        clip      = 1'b0;
        if (|sgn_q[LAST_MID]) begin
            if (shifted > SAT_SMAX) begin
                dout_next = SAT_SMAX[DOUT_WIDTH-1:0];
                clip      = 1'b1;
            end else if (shifted < SAT_SMIN) begin
                dout_next = SAT_SMIN[DOUT_WIDTH-1:0];
                clip      = 1'b1;
            end
        end else begin
            if (shifted[CALC_WIDTH-1]) begin
                dout_next = '0;
                clip      = 1'b1;
            end else if (shifted > SAT_UMAX) begin
                dout_next = SAT_UMAX[DOUT_WIDTH-1:0];
                clip      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
            out_tag   <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            out_valid <= valid_q[LAST_MID];
            if (valid_q[LAST_MID]) begin
                dout    <= dout_next;
                out_tag <= tag_q[LAST_MID];
                out_sat <= clip;
            end
        end
    end

    assign busy = (|valid_q) | out_valid;

endmodule
`default_nettype wire
